// File: rtl/micron_async_arb_ctrl_if.sv
// Two-port requester bundle for the async PSRAM arbiter: level request, latched command, registered read data, done pulse.
interface micron_async_arb_ctrl_if;
  logic        req0_en;
  logic        req0_we;
  logic [22:0] req0_addr;
  logic [15:0] req0_wdata;
  logic [1:0]  req0_be;
  logic [15:0] req0_rdata;
  logic        req0_done;

  logic        req1_en;
  logic        req1_we;
  logic [22:0] req1_addr;
  logic [15:0] req1_wdata;
  logic [1:0]  req1_be;
  logic [15:0] req1_rdata;
  logic        req1_done;

  modport master (
    output req0_en, req0_we, req0_addr, req0_wdata, req0_be,
    input  req0_rdata, req0_done,
    output req1_en, req1_we, req1_addr, req1_wdata, req1_be,
    input  req1_rdata, req1_done
  );

  modport slave (
    input  req0_en, req0_we, req0_addr, req0_wdata, req0_be,
    output req0_rdata, req0_done,
    input  req1_en, req1_we, req1_addr, req1_wdata, req1_be,
    output req1_rdata, req1_done
  );
endinterface

// File: rtl/micron_async_arb_ctrl.sv
// Two-port arbiter driving an async-mode PSRAM: IDLE -> SETUP -> ACCESS(WAIT_CYCLES) -> HOLD -> IDLE.
// Done pulses in HOLD (sampled WAIT_CYCLES+2 edges after grant); requests wait in IDLE until granted.
module micron_async_arb_ctrl #(
  parameter int WAIT_CYCLES = 4
) (
  input  logic                          clk50MHz,
  input  logic                          rst,
  micron_async_arb_ctrl_if.slave        req,
  output logic                          busy,
  output logic                          mce_L,
  output logic                          moe_L,
  output logic                          mwe_L,
  output logic                          madv_L,
  output logic                          mub_L,
  output logic                          mlb_L,
  output logic                          mclk,
  output logic                          mcre,
  output logic [22:0]                   maddr,
  inout  wire  [15:0]                   mem_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic        gnt;
  logic        last_gnt;
  logic        we_q;
  logic [22:0] addr_q;
  logic [15:0] wdata_q;
  logic [1:0]  be_q;
  logic [15:0] rdata0;
  logic [15:0] rdata1;
  logic        done0;
  logic        done1;
  logic        mem_drive;

  logic        grant_vld;
  logic        grant_sel;
  logic        sel_we;
  logic [22:0] sel_addr;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_be;
  logic        access_end;

  // Async mode only: clock, address-valid and config-register pins are static.
  assign mclk   = 1'b0;
  assign madv_L = 1'b0;
  assign mcre   = 1'b0;

  // With both ports requesting, the one not served last wins; last_gnt resets to 1 so port 0 leads.
  always_comb begin
    grant_vld = req.req0_en | req.req1_en;
    grant_sel = 1'b0;
    if (req.req0_en && req.req1_en) begin
      grant_sel = ~last_gnt;
    end else begin
      grant_sel = req.req1_en;
    end
  end

  always_comb begin
    sel_we    = req.req0_we;
    sel_addr  = req.req0_addr;
    sel_wdata = req.req0_wdata;
    sel_be    = req.req0_be;
    if (grant_sel) begin
      sel_we    = req.req1_we;
      sel_addr  = req.req1_addr;
      sel_wdata = req.req1_wdata;
      sel_be    = req.req1_be;
    end
  end

  assign access_end = (state == ACCESS) && (cnt == LAST_CNT);

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    mce_L     = 1'b1;
    moe_L     = 1'b1;
    mwe_L     = 1'b1;
    mub_L     = 1'b1;
    mlb_L     = 1'b1;
    maddr     = '0;
    mem_drive = 1'b0;
    done0     = 1'b0;
    done1     = 1'b0;

    if (state != IDLE) begin
      busy  = 1'b1;
      mce_L = 1'b0;
      maddr = addr_q;
      mub_L = ~be_q[1];
      mlb_L = ~be_q[0];
    end

    case (state)
      IDLE: begin
        if (grant_vld) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = ACCESS;
      end
      ACCESS: begin
        moe_L     = we_q;
        mwe_L     = ~we_q;
        mem_drive = we_q;
        if (cnt == LAST_CNT) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        // Write data stays on the bus one clock past mwe_L rising for hold time.
        mem_drive = we_q;
        done0     = ~gnt;
        done1     = gnt;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk50MHz) begin
    if (rst) begin
      cnt      <= '0;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      rdata0   <= '0;
      rdata1   <= '0;
    end else begin
      if (state == IDLE && grant_vld) begin
        gnt      <= grant_sel;
        last_gnt <= grant_sel;
        we_q     <= sel_we;
        addr_q   <= sel_addr;
        wdata_q  <= sel_wdata;
        be_q     <= sel_be;
      end

      if (state == SETUP) begin
        cnt <= '0;
      end else if (state == ACCESS) begin
        cnt <= cnt + 4'd1;
      end

      // Full word captured regardless of byte enables; the requester masks as needed.
      if (access_end && !we_q) begin
        if (gnt) begin
          rdata1 <= mem_data;
        end else begin
          rdata0 <= mem_data;
        end
      end
    end
  end

  assign mem_data       = mem_drive ? wdata_q : 16'hzzzz;
  assign req.req0_rdata = rdata0;
  assign req.req1_rdata = rdata1;
  assign req.req0_done  = done0;
  assign req.req1_done  = done1;

endmodule

// File: tb/tb_micron_async_arb_ctrl.sv
// Bench for micron_async_arb_ctrl: transaction table, random traffic vs. a word/byte-lane memory model, arbitration, reset and WAIT_CYCLES=1 sequences.
module tb_micron_async_arb_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  micron_async_arb_ctrl_if bus ();
  micron_async_arb_ctrl_if bus1 ();

  logic        busy, mce_L, moe_L, mwe_L, madv_L, mub_L, mlb_L, mclk, mcre;
  logic [22:0] maddr;
  wire  [15:0] mem_data;

  logic        busy_b, mce_b, moe_b, mwe_b, madv_b, mub_b, mlb_b, mclk_b, mcre_b;
  logic [22:0] maddr_b;
  wire  [15:0] mem_data_b;

  logic [15:0] sram [0:31];
  logic        probe_en;

  // Pin-level PSRAM: drives reads, stores writes per active-low byte lane.
  assign mem_data   = (!mce_L && !moe_L) ? sram[maddr[4:0]] : (probe_en ? 16'h5A5A : 16'hzzzz);
  assign mem_data_b = (!mce_b && !moe_b) ? (maddr_b[15:0] ^ 16'h3C3C) : 16'hzzzz;

  always @(posedge clk) begin
    if (!mce_L && !mwe_L) begin
      if (!mub_L) sram[maddr[4:0]][15:8] <= mem_data[15:8];
      if (!mlb_L) sram[maddr[4:0]][7:0]  <= mem_data[7:0];
    end
  end

  micron_async_arb_ctrl #(.WAIT_CYCLES(W)) dut (
    .clk50MHz(clk), .rst(rst), .req(bus), .busy(busy),
    .mce_L(mce_L), .moe_L(moe_L), .mwe_L(mwe_L), .madv_L(madv_L),
    .mub_L(mub_L), .mlb_L(mlb_L), .mclk(mclk), .mcre(mcre),
    .maddr(maddr), .mem_data(mem_data)
  );

  micron_async_arb_ctrl #(.WAIT_CYCLES(1)) dut_w1 (
    .clk50MHz(clk), .rst(rst), .req(bus1), .busy(busy_b),
    .mce_L(mce_b), .moe_L(moe_b), .mwe_L(mwe_b), .madv_L(madv_b),
    .mub_L(mub_b), .mlb_L(mlb_b), .mclk(mclk_b), .mcre(mcre_b),
    .maddr(maddr_b), .mem_data(mem_data_b)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference memory: one word per address, merged by byte enable.
  logic [15:0] ref_mem [int];

  function automatic logic [15:0] ref_rd(input logic [22:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'h0000;
  endfunction

  function automatic void ref_wr(input logic [22:0] a, input logic [15:0] d, input logic [1:0] be);
    logic [15:0] old;
    old = ref_rd(a);
    ref_mem[int'(a)] = {be[1] ? d[15:8] : old[15:8], be[0] ? d[7:0] : old[7:0]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic get_done(input int p);
    return (p != 0) ? bus.req1_done : bus.req0_done;
  endfunction

  function automatic logic [15:0] get_rdata(input int p);
    return (p != 0) ? bus.req1_rdata : bus.req0_rdata;
  endfunction

  task automatic set_req(input int p, input logic en, input logic we, input logic [22:0] a,
                         input logic [15:0] d, input logic [1:0] be);
    if (p == 0) begin
      bus.req0_en = en; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_be = be;
    end else begin
      bus.req1_en = en; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_be = be;
    end
  endtask

  task automatic set_en(input int p, input logic en);
    if (p == 0) bus.req0_en = en;
    else        bus.req1_en = en;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One complete access on port p, requested from IDLE; checks pins, latency and read data.
  task automatic run_txn(input int p, input logic we, input logic [22:0] a, input logic [15:0] d,
                         input logic [1:0] be, input logic [15:0] exp_rd);
    logic [15:0] other_before;
    int cyc, we_lo, oe_lo;
    bit seen, be_ok, addr_ok, bus_ok, other_done;
    @(negedge clk);
    other_before = get_rdata(1 - p);
    set_req(p, 1'b1, we, a, d, be);
    cyc = 0; seen = 0; we_lo = 0; oe_lo = 0;
    be_ok = 1; addr_ok = 1; bus_ok = 1; other_done = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (!mwe_L) we_lo++;
      if (!moe_L) oe_lo++;
      if (!mce_L) begin
        if (mub_L !== ~be[1] || mlb_L !== ~be[0]) be_ok = 0;
        if (maddr !== a) addr_ok = 0;
      end
      if (we && (!mwe_L || get_done(p)) && mem_data !== d) bus_ok = 0;
      if (get_done(1 - p)) other_done = 1;
      if (get_done(p)) seen = 1;
    end
    set_en(p, 1'b0);
    check("done_latency", 32'(cyc), 32'(W + 2));
    check("mwe_low_clocks", 32'(we_lo), we ? 32'(W) : 32'd0);
    check("moe_low_clocks", 32'(oe_lo), we ? 32'd0 : 32'(W));
    check("byte_lanes", 32'(be_ok), 32'd1);
    check("maddr_held", 32'(addr_ok), 32'd1);
    if (we) check("write_bus_data", 32'(bus_ok), 32'd1);
    check("other_done_quiet", 32'(other_done), 32'd0);
    check("async_pins", {29'd0, madv_L, mclk, mcre}, 32'd0);
    @(negedge clk);
    check("idle_after_hold", {30'd0, busy, mce_L}, 32'd1);
    if (!we) check("rdata", 32'(get_rdata(p)), 32'(exp_rd));
    check("other_rdata_held", 32'(get_rdata(1 - p)), 32'(other_before));
    if (we) ref_wr(a, d, be);
  endtask

  typedef struct {
    int          port;
    logic        we;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int order[$];
    int stamps[$];
    int idles[$];
    int cyc, idle_run, last_g, exp_g, ndone;
    bit both_done;

    for (int i = 0; i < 32; i++) sram[i] = 16'h0000;
    probe_en = 1'b0;
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0);
    bus1.req0_en = 0; bus1.req0_we = 0; bus1.req0_addr = '0; bus1.req0_wdata = '0; bus1.req0_be = '0;
    bus1.req1_en = 0; bus1.req1_we = 0; bus1.req1_addr = '0; bus1.req1_wdata = '0; bus1.req1_be = '0;

    vecs[0]  = '{0, 1'b1, 23'h000003, 16'hA5C3, 2'b11, 16'h0000};
    vecs[1]  = '{0, 1'b0, 23'h000003, 16'h0000, 2'b11, 16'hA5C3};
    vecs[2]  = '{1, 1'b1, 23'h000005, 16'hFFFF, 2'b11, 16'h0000};
    vecs[3]  = '{1, 1'b1, 23'h000005, 16'h1200, 2'b10, 16'h0000};
    vecs[4]  = '{0, 1'b0, 23'h000005, 16'h0000, 2'b11, 16'h12FF};
    vecs[5]  = '{1, 1'b1, 23'h000007, 16'hBEEF, 2'b01, 16'h0000};
    vecs[6]  = '{1, 1'b0, 23'h000007, 16'h0000, 2'b00, 16'h00EF};
    vecs[7]  = '{0, 1'b1, 23'h7FFFFF, 16'h1357, 2'b11, 16'h0000};
    vecs[8]  = '{1, 1'b0, 23'h7FFFFF, 16'h0000, 2'b11, 16'h1357};
    vecs[9]  = '{0, 1'b1, 23'h000009, 16'hDEAD, 2'b00, 16'h0000};
    vecs[10] = '{0, 1'b0, 23'h000009, 16'h0000, 2'b11, 16'h0000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_ctl", {27'd0, mce_L, moe_L, mwe_L, mub_L, mlb_L}, 32'h1F);
    check("rst_async_pins", {29'd0, madv_L, mclk, mcre}, 32'd0);
    check("rst_maddr", 32'(maddr), 32'd0);
    check("rst_busy_done", {29'd0, busy, bus.req0_done, bus.req1_done}, 32'd0);
    check("rst_rdata", {bus.req0_rdata, bus.req1_rdata}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i])
      run_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].exp_rdata);

    for (int i = 0; i < 40; i++) begin
      int p;
      logic we;
      logic [22:0] a;
      logic [15:0] d;
      logic [1:0] be;
      p  = int'($urandom_range(0, 1));
      we = 1'($urandom_range(0, 1));
      a  = 23'($urandom_range(0, 15));
      d  = 16'($urandom);
      be = 2'($urandom_range(0, 3));
      run_txn(p, we, a, d, be, ref_rd(a));
    end

    // Request withdrawn right after grant still completes
    @(negedge clk);
    set_req(1, 1'b1, 1'b1, 23'h00000C, 16'h0F0F, 2'b11);
    @(negedge clk);
    set_en(1, 1'b0);
    cyc = 1;
    while (!bus.req1_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("dropped_en_done_latency", 32'(cyc), 32'(W + 2));
    ref_wr(23'h00000C, 16'h0F0F, 2'b11);
    @(negedge clk);
    check("dropped_en_sram", 32'(sram[12]), 32'(ref_rd(23'h00000C)));

    // Both ports held from reset: alternating grants, port 0 first
    do_reset();
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 23'h000003, 16'h0000, 2'b11);
    set_req(1, 1'b1, 1'b0, 23'h000005, 16'h0000, 2'b11);
    cyc = 0; both_done = 0;
    while (order.size() < 4 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (bus.req0_done && bus.req1_done) both_done = 1;
      if (bus.req0_done) begin order.push_back(0); stamps.push_back(cyc); end
      if (bus.req1_done) begin order.push_back(1); stamps.push_back(cyc); end
    end
    set_en(0, 1'b0);
    set_en(1, 1'b0);
    check("arb_grant_count", 32'(order.size()), 32'd4);
    check("arb_no_double_done", 32'(both_done), 32'd0);
    last_g = 1;
    for (int i = 0; i < order.size(); i++) begin
      exp_g = 1 - last_g;
      last_g = exp_g;
      check("arb_order", 32'(order[i]), 32'(exp_g));
      if (i == 0) check("arb_first_latency", 32'(stamps[i]), 32'(W + 2));
      else        check("arb_period", 32'(stamps[i] - stamps[i-1]), 32'(W + 3));
    end
    @(negedge clk);
    check("arb_rdata0", 32'(bus.req0_rdata), 32'(ref_rd(23'h000003)));
    check("arb_rdata1", 32'(bus.req1_rdata), 32'(ref_rd(23'h000005)));

    // Reset during the second ACCESS clock of a write
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 23'h000010, 16'h1111, 2'b11);
    repeat (3) @(negedge clk);
    check("abort_pre_mwe", 32'(mwe_L), 32'd0);
    rst = 1'b1;
    set_en(0, 1'b0);
    @(negedge clk);
    check("abort_ctl", {29'd0, mwe_L, mce_L, moe_L}, 32'h7);
    check("abort_busy_done", {29'd0, busy, bus.req0_done, bus.req1_done}, 32'd0);
    check("abort_maddr", 32'(maddr), 32'd0);
    check("abort_rdata", {bus.req0_rdata, bus.req1_rdata}, 32'd0);
    probe_en = 1'b1;
    #1;
    check("abort_bus_released", 32'(mem_data), 32'h5A5A);
    probe_en = 1'b0;
    rst = 1'b0;
    ndone = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.req0_done || bus.req1_done || busy) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);

    // WAIT_CYCLES=1: port 1 reads back-to-back
    @(negedge clk);
    bus1.req1_we = 1'b0; bus1.req1_addr = 23'h000011; bus1.req1_be = 2'b11; bus1.req1_en = 1'b1;
    cyc = 0; idle_run = 0;
    while (stamps.size() < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus1.req1_done) begin
        if (stamps.size() > 4) idles.push_back(idle_run);
        stamps.push_back(cyc);
        idle_run = 0;
      end else if (mce_b) begin
        idle_run++;
      end
    end
    bus1.req1_en = 1'b0;
    check("w1_done_count", 32'(stamps.size()), 32'd8);
    for (int i = 5; i < stamps.size(); i++)
      check("w1_period", 32'(stamps[i] - stamps[i-1]), 32'd4);
    foreach (idles[i])
      check("w1_idle_gap", 32'(idles[i]), 32'd1);
    @(negedge clk);
    check("w1_rdata", 32'(bus1.req1_rdata), 32'h3C2D);
    check("w1_quiet", {27'd0, bus1.req0_done, madv_b, mclk_b, mcre_b, mwe_b}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
